// File: rtl/kvs_req_ctrl.sv
// Initiator side of the KVS request/response link: issues requests to db_top, matches in-order responses to packet tags.
// Latency: in_valid 1 cycle after accept; result 1 cycle after out_valid or after the head request times out.
// Backpressure: pkt_ready drops while pending plus timed-out-but-unanswered requests fill MAX_OUTSTANDING slots.
module kvs_req_ctrl #(
    parameter int KEY_SIZE        = 96,
    parameter int ID_W            = 8,
    parameter int MAX_OUTSTANDING = 8,
    parameter int TIMEOUT         = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_SIZE-1:0] pkt_key,
    input  logic [3:0]          pkt_op,
    input  logic [ID_W-1:0]     pkt_id,
    input  logic                pkt_valid,
    output logic                pkt_ready,
    output logic [KEY_SIZE-1:0] in_key,
    output logic [3:0]          in_flag,
    output logic                in_valid,
    input  logic                out_valid,
    input  logic [3:0]          out_flag,
    output logic                res_valid,
    output logic [ID_W-1:0]     res_id,
    output logic [3:0]          res_flag,
    output logic                res_hit,
    output logic                res_timeout,
    output logic [15:0]         stale_cnt,
    output logic                err_spurious
);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;
    localparam int AW = $clog2(TIMEOUT) + 1;
    localparam logic [CW:0]   CAP     = (CW + 1)'(MAX_OUTSTANDING);
    localparam logic [AW-1:0] AGE_LIM = AW'(TIMEOUT - 1);

    logic [ID_W-1:0] mem [MAX_OUTSTANDING];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_nxt, expired_cnt;
    logic [CW:0]     occ;
    logic [AW-1:0]   age;
    logic            accept, stale_hit, resp_pop, spurious, timeout_pop, pop;

    // Timed-out requests keep their slot until their late response drains it.
    assign occ       = {1'b0, count} + {1'b0, expired_cnt};
    assign pkt_ready = !rst && (occ < CAP);
    assign accept    = pkt_valid && pkt_ready;

    assign stale_hit   = out_valid && (expired_cnt != '0);
    assign resp_pop    = out_valid && (expired_cnt == '0) && (count != '0);
    assign spurious    = out_valid && (expired_cnt == '0) && (count == '0);
    // >= rather than == so a stale response landing on the limit cycle only defers the timeout.
    assign timeout_pop = !out_valid && (count != '0) && (age >= AGE_LIM);
    assign pop         = resp_pop || timeout_pop;
    assign count_nxt   = count + CW'(accept) - CW'(pop);

    assign res_hit = res_flag[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            expired_cnt  <= '0;
            age          <= '0;
            stale_cnt    <= '0;
            err_spurious <= 1'b0;
            in_valid     <= 1'b0;
            in_key       <= '0;
            in_flag      <= '0;
            res_valid    <= 1'b0;
            res_id       <= '0;
            res_flag     <= '0;
            res_timeout  <= 1'b0;
        end else begin
            in_valid <= accept;
            if (accept) begin
                in_key  <= pkt_key;
                in_flag <= pkt_op;
                wr_ptr  <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count_nxt;

            if (timeout_pop)
                expired_cnt <= expired_cnt + CW'(1);
            else if (stale_hit)
                expired_cnt <= expired_cnt - CW'(1);

            if (stale_hit && (stale_cnt != 16'hFFFF))
                stale_cnt <= stale_cnt + 16'd1;
            if (spurious)
                err_spurious <= 1'b1;

            // The age always belongs to whichever request is at the head after this cycle.
            age <= (pop || (count_nxt == '0)) ? '0 : age + AW'(1);

            res_valid   <= pop;
            res_timeout <= timeout_pop;
            if (pop) begin
                res_id   <= mem[rd_ptr];
                res_flag <= resp_pop ? out_flag : 4'h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= pkt_id;
    end
endmodule
